// File: rtl/mult_serial_ctrl.sv
// -----------------------------------------------------------------------------
// mult_serial_ctrl
//
// Sequencer for an external combinational multiplier. Operands A and B are
// shifted in LSB first from two pins and presented in parallel to the
// multiplier. After a programmable settle time the product is captured and
// shifted back out LSB first with a valid strobe, followed by a one-cycle
// done pulse.
//
// State flow: IDLE -> LOAD -> SETTLE -> UNLOAD -> DONE -> IDLE
//
// Parameters:
//   OP_W        operand width; product width is 2*OP_W
//   SETTLE_CYC  whole cycles between last operand bit and product capture
//               (0..15); SETTLE therefore lasts SETTLE_CYC+1 cycles
//
// Ports:
//   wb_clk_i     clock, all logic on the rising edge
//   wb_rst_i     synchronous active-high reset
//   start_i      begin a transaction (honoured only in IDLE)
//   a_bit_i      serial operand A, LSB first
//   b_bit_i      serial operand B, LSB first
//   mult_a_o     parallel operand A to the multiplier
//   mult_b_o     parallel operand B to the multiplier
//   mult_p_i     product from the multiplier
//   busy_o       high whenever the sequencer is not in IDLE
//   p_bit_o      serial product bit, low lane
//   p_bit_hi_o   serial product bit, high lane (0 unless dual-lane build)
//   p_valid_o    p_bit_o / p_bit_hi_o carry a valid bit this cycle
//   done_o       one-cycle pulse after the final product bit
//
// Build option:
//   MULT_DUAL_LANE_EN  when defined, the product leaves on two lanes at once:
//                      p_bit_o carries the low half and p_bit_hi_o the high
//                      half, so UNLOAD lasts OP_W cycles instead of 2*OP_W.
// -----------------------------------------------------------------------------
module mult_serial_ctrl #(
  parameter int OP_W       = 16,
  parameter int SETTLE_CYC = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic              a_bit_i,
  input  logic              b_bit_i,
  output logic [OP_W-1:0]   mult_a_o,
  output logic [OP_W-1:0]   mult_b_o,
  input  logic [2*OP_W-1:0] mult_p_i,
  output logic              busy_o,
  output logic              p_bit_o,
  output logic              p_bit_hi_o,
  output logic              p_valid_o,
  output logic              done_o
);

  localparam int P_W = 2 * OP_W;

`ifdef MULT_DUAL_LANE_EN
  localparam int UNLOAD_LEN = OP_W;
`else
  localparam int UNLOAD_LEN = P_W;
`endif

  // One counter serves LOAD, SETTLE and UNLOAD; size it for the longest phase.
  localparam int CNT_MAX = (P_W > SETTLE_CYC + 1) ? P_W : SETTLE_CYC + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(OP_W - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] UNLOAD_LAST = CNT_W'(UNLOAD_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_UNLOAD,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic [P_W-1:0]    p_q, p_d;
  logic              p_bit_q, p_bit_d;
  logic              p_hi_q, p_hi_d;
  logic              p_valid_q, p_valid_d;
  logic              done_q, done_d;
  logic [OP_W-1:0]   bit_mask;

  // Selects operand bit position cnt_q during LOAD.
  assign bit_mask = OP_W'(1) << cnt_q;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    p_d       = p_q;
    p_bit_d   = 1'b0;
    p_hi_d    = 1'b0;
    p_valid_d = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Operand pins are not sampled on the start edge.
        if (start_i) begin
          a_d     = '0;
          b_d     = '0;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // Registers were cleared on start, so OR-ing in each bit is enough.
        if (a_bit_i) a_d = a_q | bit_mask;
        if (b_bit_i) b_d = b_q | bit_mask;
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          p_d     = mult_p_i;
          cnt_d   = '0;
          state_d = S_UNLOAD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_UNLOAD: begin
        // The product register shifts right, so bit 0 is always p_reg[cnt]
        // and bit OP_W is p_reg[OP_W+cnt] of the captured word.
        p_valid_d = 1'b1;
        p_bit_d   = p_q[0];
`ifdef MULT_DUAL_LANE_EN
        p_hi_d    = p_q[OP_W];
`endif
        p_d       = p_q >> 1;
        if (cnt_q == UNLOAD_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DONE: begin
        // start_i is deliberately ignored here; it is not queued.
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of evaluation order.
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      p_bit_q   <= 1'b0;
      p_hi_q    <= 1'b0;
      p_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      p_q       <= p_d;
      p_bit_q   <= p_bit_d;
      p_hi_q    <= p_hi_d;
      p_valid_q <= p_valid_d;
      done_q    <= done_d;
    end
  end

  assign mult_a_o   = a_q;
  assign mult_b_o   = b_q;
  assign busy_o     = (state_q != S_IDLE);
  assign p_bit_o    = p_bit_q;
  assign p_bit_hi_o = p_hi_q;
  assign p_valid_o  = p_valid_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_mult_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_serial_ctrl
//
// Three instances of mult_serial_ctrl share one stimulus stream and differ only
// in SETTLE_CYC (2, 0, 3). A behavioural multiplier (or a forced product word)
// drives each mult_p_i. The driver pushes the expected product word and done
// cycle per instance; a monitor rebuilds the serial stream and compares on
// done_o. Builds with or without MULT_DUAL_LANE_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mult_serial_ctrl;

  localparam int OP_W = 16;
  localparam int P_W  = 2 * OP_W;
  localparam int NDUT = 3;

`ifdef MULT_DUAL_LANE_EN
  localparam int UNL = OP_W;
`else
  localparam int UNL = P_W;
`endif

  typedef struct {
    logic [P_W-1:0] word;
    int             done_cyc;
  } exp_t;

  logic            clk      = 1'b0;
  logic            rst      = 1'b1;
  logic            start    = 1'b0;
  logic            a_bit    = 1'b0;
  logic            b_bit    = 1'b0;
  logic [OP_W-1:0] mult_a  [NDUT];
  logic [OP_W-1:0] mult_b  [NDUT];
  logic [P_W-1:0]  mult_p  [NDUT];
  logic            busy    [NDUT];
  logic            p_bit   [NDUT];
  logic            p_hi    [NDUT];
  logic            p_valid [NDUT];
  logic            done    [NDUT];

  logic            ovr_en  = 1'b0;
  logic [P_W-1:0]  ovr_val = '0;
  logic [P_W-1:0]  ovr_alt = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  mult_serial_ctrl #(.OP_W(OP_W), .SETTLE_CYC(2)) u_dut_s2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .a_bit_i(a_bit), .b_bit_i(b_bit),
    .mult_a_o(mult_a[0]), .mult_b_o(mult_b[0]), .mult_p_i(mult_p[0]), .busy_o(busy[0]),
    .p_bit_o(p_bit[0]), .p_bit_hi_o(p_hi[0]), .p_valid_o(p_valid[0]), .done_o(done[0])
  );

  mult_serial_ctrl #(.OP_W(OP_W), .SETTLE_CYC(0)) u_dut_s0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .a_bit_i(a_bit), .b_bit_i(b_bit),
    .mult_a_o(mult_a[1]), .mult_b_o(mult_b[1]), .mult_p_i(mult_p[1]), .busy_o(busy[1]),
    .p_bit_o(p_bit[1]), .p_bit_hi_o(p_hi[1]), .p_valid_o(p_valid[1]), .done_o(done[1])
  );

  mult_serial_ctrl #(.OP_W(OP_W), .SETTLE_CYC(3)) u_dut_s3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .a_bit_i(a_bit), .b_bit_i(b_bit),
    .mult_a_o(mult_a[2]), .mult_b_o(mult_b[2]), .mult_p_i(mult_p[2]), .busy_o(busy[2]),
    .p_bit_o(p_bit[2]), .p_bit_hi_o(p_hi[2]), .p_valid_o(p_valid[2]), .done_o(done[2])
  );

  // Multiplier model, or a forced word for capture-timing tests.
  always_comb begin
    for (int i = 0; i < NDUT; i++) begin
      mult_p[i] = ovr_en ? ovr_val : (P_W'(mult_a[i]) * P_W'(mult_b[i]));
    end
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [P_W-1:0] act, input logic [P_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int settle_of(input int i);
    case (i)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  // Start edge to done_o-high edge.
  function automatic int latency(input int i);
    return 1 + OP_W + (settle_of(i) + 1) + UNL;
  endfunction

  function automatic void push_exp(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int q_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t pop_exp(input int i);
    exp_t e;
    case (i)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: rebuild the serial product and compare on done_o
  // ---------------------------------------------------------------------------
  logic [P_W-1:0] acc     [NDUT];
  int             nb      [NDUT];
  bit             hi_seen [NDUT];
  exp_t           mon_e;

  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (rst || (!busy[i] && !done[i])) begin
        acc[i]     = '0;
        nb[i]      = 0;
        hi_seen[i] = 1'b0;
      end else begin
        if (p_valid[i]) begin
          if (nb[i] < UNL) begin
            acc[i][nb[i]] = p_bit[i];
`ifdef MULT_DUAL_LANE_EN
            acc[i][OP_W + nb[i]] = p_hi[i];
`endif
          end
          if (p_hi[i]) hi_seen[i] = 1'b1;
          nb[i]++;
        end
        if (done[i]) begin
          if (q_size(i) == 0) begin
            check($sformatf("dut%0d_unexpected_done", i), P_W'(done[i]), '0);
          end else begin
            mon_e = pop_exp(i);
            check($sformatf("dut%0d_product", i), acc[i], mon_e.word);
            check($sformatf("dut%0d_valid_bits", i), P_W'(nb[i]), P_W'(UNL));
            check($sformatf("dut%0d_done_cycle", i), P_W'(cyc), P_W'(mon_e.done_cyc));
`ifndef MULT_DUAL_LANE_EN
            check($sformatf("dut%0d_hi_lane_quiet", i), P_W'(hi_seen[i]), '0);
`endif
          end
          acc[i]     = '0;
          nb[i]      = 0;
          hi_seen[i] = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  //   e0/e1/e2  expected word for SETTLE_CYC 2/0/3 instances
  //   sw_edge   >=0: forced product switches to ovr_alt after edge start+sw_edge
  //   poke      pulse start_i during LOAD bit 5 and during UNLOAD bit 10
  //   rst_edge  >=0: reset sampled on edge start+rst_edge, transaction aborted
  // ---------------------------------------------------------------------------
  task automatic run_txn(input string tag,
                         input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                         input logic [P_W-1:0] e0, input logic [P_W-1:0] e1,
                         input logic [P_W-1:0] e2,
                         input int sw_edge, input bit poke, input int rst_edge);
    int   s;
    bit   finished;
    exp_t e;

    @(negedge clk);
    start = 1'b1;
    a_bit = 1'b1;   // ignored on the start edge
    b_bit = 1'b1;
    s     = cyc + 1;

    if (rst_edge < 0) begin
      for (int i = 0; i < NDUT; i++) begin
        e.word     = (i == 0) ? e0 : ((i == 1) ? e1 : e2);
        e.done_cyc = s + latency(i);
        push_exp(i, e);
      end
    end

    for (int k = 0; k < OP_W; k++) begin
      @(negedge clk);
      start = poke && (k == 5);
      a_bit = a[k];
      b_bit = b[k];
    end

    @(negedge clk);
    start = 1'b0;
    a_bit = 1'b0;
    b_bit = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("%s_dut%0d_mult_a", tag, i), P_W'(mult_a[i]), P_W'(a));
      check($sformatf("%s_dut%0d_mult_b", tag, i), P_W'(mult_b[i]), P_W'(b));
    end

    finished = 1'b0;
    for (int n = 0; n < 200 && !finished; n++) begin
      if (sw_edge >= 0 && cyc == s + sw_edge) ovr_val = ovr_alt;
      if (poke) start = (cyc == s + 29);
      if (rst_edge >= 0 && cyc == s + rst_edge - 1) rst = 1'b1;
      if (rst_edge >= 0 && cyc == s + rst_edge) begin
        rst = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
          check($sformatf("%s_dut%0d_busy", tag, i), P_W'(busy[i]), '0);
          check($sformatf("%s_dut%0d_p_valid", tag, i), P_W'(p_valid[i]), '0);
          check($sformatf("%s_dut%0d_done", tag, i), P_W'(done[i]), '0);
          check($sformatf("%s_dut%0d_mult_a", tag, i), P_W'(mult_a[i]), '0);
        end
        finished = 1'b1;
      end else if (cyc > s + OP_W && !busy[0] && !busy[1] && !busy[2]) begin
        finished = 1'b1;
      end
      if (!finished) @(negedge clk);
    end

    if (!finished) begin
      check($sformatf("%s_timeout_busy", tag), P_W'({busy[0], busy[1], busy[2]}), '0);
    end else if (rst_edge < 0) begin
      // Operands must hold after completion until the next start.
      check($sformatf("%s_mult_a_hold", tag), P_W'(mult_a[0]), P_W'(a));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("rst_dut%0d_outputs", i),
            P_W'({busy[i], p_bit[i], p_hi[i], p_valid[i], done[i]}), '0);
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        check($sformatf("idle_dut%0d_outputs", i),
              P_W'({busy[i], p_bit[i], p_hi[i], p_valid[i], done[i]}), '0);
        check($sformatf("idle_dut%0d_operands", i), P_W'({mult_a[i], mult_b[i]}), '0);
      end
    end

    // Basic: 3 * 5 = 0xF from the multiplier model.
    run_txn("basic", 16'h0003, 16'h0005,
            32'h0000000F, 32'h0000000F, 32'h0000000F, -1, 1'b0, -1);

    // Capture timing: capture edges are start+19 (S=2), +17 (S=0), +20 (S=3).
    ovr_en  = 1'b1;
    ovr_val = 32'h11111111;
    ovr_alt = 32'h22222222;
    run_txn("cap17", 16'h0003, 16'h0005,
            32'h22222222, 32'h11111111, 32'h22222222, 17, 1'b0, -1);
    ovr_val = 32'h11111111;
    run_txn("cap19", 16'h0003, 16'h0005,
            32'h11111111, 32'h11111111, 32'h22222222, 19, 1'b0, -1);
    ovr_en  = 1'b0;

    // Start pulses while busy: 0x1234 * 0x0010 = 0x00012340, single done.
    run_txn("busy_start", 16'h1234, 16'h0010,
            32'h00012340, 32'h00012340, 32'h00012340, -1, 1'b1, -1);

    // Reset in the middle of UNLOAD, then a clean transaction.
    run_txn("mid_reset", 16'h00FF, 16'h0101,
            '0, '0, '0, -1, 1'b0, 32);
    repeat (3) @(negedge clk);
    run_txn("after_reset", 16'hFFFF, 16'h8000,
            32'h7FFF8000, 32'h7FFF8000, 32'h7FFF8000, -1, 1'b0, -1);

    // Lane split: low half 0x5678, high half 0xABCD.
    ovr_en  = 1'b1;
    ovr_val = 32'hABCD5678;
    run_txn("lanes", 16'h1234, 16'h0010,
            32'hABCD5678, 32'hABCD5678, 32'hABCD5678, -1, 1'b0, -1);
    ovr_en  = 1'b0;

    repeat (5) @(negedge clk);
    check("scoreboard_drained", P_W'(q0.size() + q1.size() + q2.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_serial_ctrl.md
Name: mult_serial_ctrl

Overview:
- Sequencer for the 16x16 combinational multiplier core; owns the pad-level serial protocol.
- Shifts operands A and B in bit-serially from two input pins and drives them in parallel to the multiplier.
- Waits a programmable settle time, then captures the product and shifts it out bit-serially with valid/done strobes.
- Replaces ad-hoc counter logic in the user project wrapper; the multiplier core is instantiated alongside it, not inside it.

Parameters:
- OP_W, 16, operand width in bits; product width is 2*OP_W.
- SETTLE_CYC, 2, whole cycles between last operand bit and product capture (0..15 legal).

Ports:
- wb_clk_i  input  1  single clock, all logic on rising edge
- wb_rst_i  input  1  synchronous, active-high reset
- start_i  input  1  begin a transaction; honoured only in IDLE
- a_bit_i  input  1  serial operand A, LSB first
- b_bit_i  input  1  serial operand B, LSB first
- mult_a_o  output  OP_W  parallel operand A to multiplier
- mult_b_o  output  OP_W  parallel operand B to multiplier
- mult_p_i  input  2*OP_W  product from multiplier
- busy_o  output  1  high whenever state != IDLE
- p_bit_o  output  1  serial product bit (low lane)
- p_bit_hi_o  output  1  serial product bit (high lane; see Optional Feature)
- p_valid_o  output  1  p_bit_o / p_bit_hi_o carry a valid bit this cycle
- done_o  output  1  one-cycle pulse after the final product bit

Behaviour:
- Reset is synchronous, active-high, on wb_clk_i; clock and reset are wb_clk_i / wb_rst_i.
- Reset state: IDLE, all counters 0, operand and product registers 0.
- Reset values: busy_o=0, p_bit_o=0, p_bit_hi_o=0, p_valid_o=0, done_o=0, mult_a_o=0, mult_b_o=0.
- Reset asserted in any state returns to IDLE on that edge and aborts the transaction; no done_o.
- States: IDLE -> LOAD -> SETTLE -> UNLOAD -> DONE -> IDLE.
- IDLE:
  - start_i=1 sampled -> clear operand regs and bit counter, go LOAD.
  - a_bit_i / b_bit_i are ignored on the start edge.
- LOAD:
  - On each edge, a_bit_i -> A[cnt] and b_bit_i -> B[cnt]; cnt increments.
  - After OP_W edges (cnt reaches OP_W-1 and is written), go SETTLE with cnt=0.
  - mult_a_o / mult_b_o reflect operand registers continuously and hold until the next start.
- SETTLE:
  - Lasts SETTLE_CYC+1 cycles.
  - On the final edge, capture mult_p_i into p_reg, go UNLOAD, cnt=0.
  - With SETTLE_CYC=0, capture occurs on the edge after the last operand bit.
- UNLOAD (single lane):
  - Registered outputs: p_valid_o=1, p_bit_o=p_reg[cnt] for cnt=0..2*OP_W-1, i.e. 2*OP_W cycles, LSB first.
  - The first valid bit appears the cycle after capture.
  - p_bit_hi_o held 0.
- DONE:
  - One cycle: done_o=1, p_valid_o=0; then IDLE.
  - busy_o falls on the same edge that DONE exits.
- start_i is ignored while busy_o=1, including in DONE. It is not queued.
- Counters are sized for the maximum of OP_W, 2*OP_W and SETTLE_CYC+1; no wrap occurs in legal operation.
- Total latency from start edge to done_o high: 1 + OP_W + (SETTLE_CYC+1) + 2*OP_W cycles = 52 at defaults (single lane).

Optional Feature:
- Macro: MULT_DUAL_LANE_EN.
- Defined:
  - UNLOAD lasts OP_W cycles.
  - p_bit_o = p_reg[cnt] and p_bit_hi_o = p_reg[OP_W+cnt] for cnt=0..OP_W-1.
  - Latency becomes 1 + OP_W + (SETTLE_CYC+1) + OP_W = 36 at defaults.
- Undefined: single-lane behaviour above; p_bit_hi_o tied 0.

Test Plan:
- Reset/idle: wb_rst_i high 3 cycles, then low; start_i=0 for 10 cycles -> all outputs 0, busy_o=0 throughout.
- Basic transaction: start, shift A=0x0003, B=0x0005; bench model drives mult_p_i=0x0000000F.
  - Expect mult_a_o=0x0003 and mult_b_o=0x0005 after LOAD.
  - Expect 32 valid bits reconstructing 0x0000000F, done_o exactly at cycle 52 after start.
- Capture timing: SETTLE_CYC=0 vs 3; bench changes mult_p_i from 0x11111111 to 0x22222222 at a known cycle -> captured word must match the value present on the defined capture edge only.
- Start while busy: pulse start_i during LOAD bit 5 and during UNLOAD bit 10 -> no restart; operands and output stream unaffected; only one done_o.
- Reset mid-UNLOAD: assert wb_rst_i at product bit 12 -> next cycle IDLE, p_valid_o=0, mult_a_o=0, no done_o.
  - A following transaction with A=0xFFFF, B=0x8000 completes normally.
- MULT_DUAL_LANE_EN build, A=0x1234, B=0x0010, mult_p_i=0xABCD5678:
  - p_bit_o stream = 0x5678, p_bit_hi_o stream = 0xABCD over 16 valid cycles.
  - done_o at cycle 36.
